// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall control bundle between the MIPS pipeline and hazard_stall_ctrl.
// slave: the controller side (samples hazard status, drives pipe controls).
// master: the pipeline side (drives hazard status, samples pipe controls).
// Stall_Cnt_o exists only when HAZARD_PERF_EN is defined.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic [4:0]       IF_ID_Rs_i;
  logic [4:0]       IF_ID_Rt_i;
  logic [4:0]       ID_EX_Rt_i;
  logic             ID_EX_MemRead_i;
  logic             Branch_Taken_i;
  logic             Jump_i;
  logic             Mem_Req_i;
  logic             Mem_Ack_i;
  logic             PC_Write_o;
  logic             IF_ID_Write_o;
  logic             IF_ID_Flush_o;
  logic             ID_EX_Bubble_o;
  logic             Pipe_Stall_o;
  logic             Mem_Err_o;
  logic [1:0]       State_o;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] Stall_Cnt_o;
`endif

  modport slave (
    input  IF_ID_Rs_i, IF_ID_Rt_i, ID_EX_Rt_i, ID_EX_MemRead_i,
    input  Branch_Taken_i, Jump_i, Mem_Req_i, Mem_Ack_i,
    output PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Bubble_o,
    output Pipe_Stall_o, Mem_Err_o, State_o
`ifdef HAZARD_PERF_EN
    , output Stall_Cnt_o
`endif
  );

  modport master (
    output IF_ID_Rs_i, IF_ID_Rt_i, ID_EX_Rt_i, ID_EX_MemRead_i,
    output Branch_Taken_i, Jump_i, Mem_Req_i, Mem_Ack_i,
    input  PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Bubble_o,
    input  Pipe_Stall_o, Mem_Err_o, State_o
`ifdef HAZARD_PERF_EN
    , input Stall_Cnt_o
`endif
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Handles load-use bubbles, multi-cycle data-memory freeze with timeout,
// and IF/ID flush on taken branch/jump. Priority: memory > load-use > flush.
// Optional macro HAZARD_PERF_EN adds a saturating stall-cycle counter
// (Stall_Cnt_o) counting every cycle with PC_Write_o low outside reset.
module hazard_stall_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  hazard_stall_ctrl_if.slave  hif
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic lu;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_stall, mem_err;

  // Load-use hazard: load in EX writes a register the ID instruction reads ($0 never hazards).
  assign lu = hif.ID_EX_MemRead_i && (hif.ID_EX_Rt_i != 5'd0) &&
              ((hif.ID_EX_Rt_i == hif.IF_ID_Rs_i) || (hif.ID_EX_Rt_i == hif.IF_ID_Rt_i));

  // Next state, timeout counter and combinational pipe controls.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_stall   = 1'b1;
    mem_err      = 1'b0;
    case (state_q)
      RUN: begin
        if (hif.Mem_Req_i && !hif.Mem_Ack_i) begin
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          pipe_stall   = 1'b0;
          pc_write     = !lu;
          if_id_write  = !lu;
          id_ex_bubble = lu;
          // With a load-use stall IF/ID holds, so the branch re-presents next cycle.
          if_id_flush  = !lu && (hif.Branch_Taken_i || hif.Jump_i);
        end
      end
      MEM_WAIT: begin
        if (hif.Mem_Ack_i) begin
          // Ack beats a coincident timeout; the pipe advances in the ack cycle.
          state_d      = RUN;
          cnt_d        = '0;
          pipe_stall   = 1'b0;
          pc_write     = !lu;
          if_id_write  = !lu;
          id_ex_bubble = lu;
          if_id_flush  = !lu && (hif.Branch_Taken_i || hif.Jump_i);
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERROR: begin
        mem_err = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    // Held in reset: keep the pipe frozen with everything else quiet.
    if (!rst_i) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_stall   = 1'b1;
      mem_err      = 1'b0;
    end
  end

  // State and timeout counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hif.PC_Write_o     = pc_write;
  assign hif.IF_ID_Write_o  = if_id_write;
  assign hif.IF_ID_Flush_o  = if_id_flush;
  assign hif.ID_EX_Bubble_o = id_ex_bubble;
  assign hif.Pipe_Stall_o   = pipe_stall;
  assign hif.Mem_Err_o      = mem_err;
  assign hif.State_o        = state_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles in which the PC did not advance.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign hif.Stall_Cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl (TIMEOUT=4).
module tb_hazard_stall_ctrl;
  logic clk_i = 1'b0;
  logic rst_i;
  int   n_chk = 0;
  int   n_err = 0;

  hazard_stall_ctrl_if #(.CNT_W(16)) hif ();

  hazard_stall_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .hif   (hif.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] ex_rt, input logic [4:0] id_rs,
                       input logic [4:0] id_rt, input logic br, input logic jp,
                       input logic req, input logic ack);
    hif.ID_EX_MemRead_i = mr;
    hif.ID_EX_Rt_i      = ex_rt;
    hif.IF_ID_Rs_i      = id_rs;
    hif.IF_ID_Rt_i      = id_rt;
    hif.Branch_Taken_i  = br;
    hif.Jump_i          = jp;
    hif.Mem_Req_i       = req;
    hif.Mem_Ack_i       = ack;
  endtask

  task automatic expect_out(input string tag, input logic pc, input logic ifw, input logic fl,
                            input logic bub, input logic st, input logic err,
                            input logic [1:0] state);
    check({tag, ".pc"},    {31'd0, hif.PC_Write_o},     {31'd0, pc});
    check({tag, ".ifw"},   {31'd0, hif.IF_ID_Write_o},  {31'd0, ifw});
    check({tag, ".flush"}, {31'd0, hif.IF_ID_Flush_o},  {31'd0, fl});
    check({tag, ".bub"},   {31'd0, hif.ID_EX_Bubble_o}, {31'd0, bub});
    check({tag, ".stall"}, {31'd0, hif.Pipe_Stall_o},   {31'd0, st});
    check({tag, ".err"},   {31'd0, hif.Mem_Err_o},      {31'd0, err});
    check({tag, ".state"}, {30'd0, hif.State_o},        {30'd0, state});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with hazards and a memory request present: outputs must stay at reset values.
    rst_i = 1'b0;
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    expect_out("rst", 0, 0, 0, 0, 1, 0, 2'b00);
    tick();
    tick();
    idle();
    rst_i = 1'b1;
    #1;
    expect_out("idle", 1, 1, 0, 0, 0, 0, 2'b00);
    tick();

    // Load-use via Rs, then hazard gone next cycle.
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    expect_out("lu_rs", 0, 0, 0, 1, 0, 0, 2'b00);
    tick();
    drive(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    expect_out("lu_next", 1, 1, 0, 0, 0, 0, 2'b00);
    tick();

    // Load-use via Rt.
    drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    expect_out("lu_rt", 0, 0, 0, 1, 0, 0, 2'b00);
    tick();

    // Register 0 never causes a bubble.
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    expect_out("r0", 1, 1, 0, 0, 0, 0, 2'b00);
    tick();

    // Branch taken and jump flush IF/ID.
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    expect_out("br", 1, 1, 1, 0, 0, 0, 2'b00);
    tick();
    drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    expect_out("jmp", 1, 1, 1, 0, 0, 0, 2'b00);
    tick();

    // Branch with load-use: bubble only, flush the following cycle.
    drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    expect_out("br_lu", 0, 0, 0, 1, 0, 0, 2'b00);
    tick();
    drive(1'b0, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    expect_out("br_after", 1, 1, 1, 0, 0, 0, 2'b00);
    tick();

    // Zero-wait memory access: no stall, stays in RUN.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    expect_out("zw", 1, 1, 0, 0, 0, 0, 2'b00);
    tick();
    idle();
    #1;
    expect_out("zw_after", 1, 1, 0, 0, 0, 0, 2'b00);
    tick();

    // Memory wait: ack low for 3 cycles, then high.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    expect_out("mw0", 0, 0, 0, 0, 1, 0, 2'b00);
    tick();
    expect_out("mw1", 0, 0, 0, 0, 1, 0, 2'b01);
    tick();
    expect_out("mw2", 0, 0, 0, 0, 1, 0, 2'b01);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    expect_out("mw_ack", 1, 1, 0, 0, 0, 0, 2'b01);
    tick();
    idle();
    #1;
    expect_out("mw_done", 1, 1, 0, 0, 0, 0, 2'b00);
    tick();

    // Timeout: 4 wait cycles without ack, then sticky ERROR.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("to_wait%0d", i), 0, 0, 0, 0, 1, 0, 2'b01);
      tick();
    end
    expect_out("to_err", 0, 0, 0, 0, 1, 1, 2'b10);
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    expect_out("err_hold", 0, 0, 0, 0, 1, 1, 2'b10);
    tick();
    expect_out("err_hold2", 0, 0, 0, 0, 1, 1, 2'b10);
    rst_i = 1'b0;
    #1;
    expect_out("err_rst", 0, 0, 0, 0, 1, 0, 2'b00);
    tick();
    idle();
    rst_i = 1'b1;
    #1;
    expect_out("err_rel", 1, 1, 0, 0, 0, 0, 2'b00);
    tick();

    // Ack arriving in the exact timeout cycle wins.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    expect_out("to_ack", 1, 1, 0, 0, 0, 0, 2'b01);
    tick();
    idle();
    #1;
    expect_out("to_ack_after", 1, 1, 0, 0, 0, 0, 2'b00);
    tick();

    // Reset asserted in the middle of MEM_WAIT.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    expect_out("wait_pre", 0, 0, 0, 0, 1, 0, 2'b01);
    rst_i = 1'b0;
    #1;
    expect_out("wait_rst", 0, 0, 0, 0, 1, 0, 2'b00);
    idle();
    tick();
    rst_i = 1'b1;
    #1;
    expect_out("wait_rel", 1, 1, 0, 0, 0, 0, 2'b00);
    tick();

`ifdef HAZARD_PERF_EN
    // Three stalled cycles of memory wait plus one load-use bubble.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    check("perf_cnt", {16'd0, hif.Stall_Cnt_o}, 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
